// File: rtl/mem_access_if.sv
// CPU-side request/response channel of the memory access unit.
// The unit is the slave; the CPU or bench is the master.
interface mem_access_if #(
  parameter int ADDRESS_SIZE = 11
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [63:0]             req_wdata;
  logic                    resp_valid;
  logic                    resp_error;
  logic [63:0]             resp_rdata;

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_error,
    input  resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_error,
    output resp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sized load/store unit in front of a 64-bit big-endian RAM.
// Partial stores go through read-modify-write of the 8-byte window.
module mem_access_unit #(
  parameter int ADDRESS_SIZE = 11,
  parameter int MEM_DEPTH    = 2**ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_access_if.slave             cpu,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic                    ram_isReading,
  output logic [63:0]             ram_dataIn,
  input  logic [63:0]             ram_dataOut
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [31:0] LAST_OK = 32'(MEM_DEPTH - 8);

  logic [1:0]              state;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [1:0]              size_q;
  logic                    write_q;
  logic                    signed_q;
  logic                    err_q;
  logic [63:0]             wdata_q;
  logic [63:0]             word_q;

  logic        accept;
  logic        bad_addr;
  logic [63:0] merged;
  logic [63:0] load_val;

  assign accept   = cpu.req_valid && cpu.req_ready;
  // Any access whose 8-byte window would run past the end is refused.
  assign bad_addr = 32'(cpu.req_addr) > LAST_OK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= SZ_B;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= cpu.req_addr;
            size_q   <= cpu.req_size;
            write_q  <= cpu.req_write;
            signed_q <= cpu.req_signed;
            wdata_q  <= cpu.req_wdata;
            err_q    <= bad_addr;
            if (bad_addr)
              state <= RESP;
            else if (cpu.req_write && cpu.req_size == SZ_D)
              state <= WR;
            else
              state <= RD;
          end
        end
        RD: begin
          word_q <= ram_dataOut;
          state  <= write_q ? WR : RESP;
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Big-endian: the addressed field is the top N bytes of the window.
  always_comb begin
    merged = word_q;
    unique case (size_q)
      SZ_B:    merged[63:56] = wdata_q[7:0];
      SZ_H:    merged[63:48] = wdata_q[15:0];
      SZ_W:    merged[63:32] = wdata_q[31:0];
      default: merged        = wdata_q;
    endcase
  end

  always_comb begin
    load_val = word_q;
    unique case (size_q)
      SZ_B: load_val = {{56{signed_q & word_q[63]}},
                        word_q[63:56]};
      SZ_H: load_val = {{48{signed_q & word_q[63]}},
                        word_q[63:48]};
      SZ_W: load_val = {{32{signed_q & word_q[63]}},
                        word_q[63:32]};
      default: load_val = word_q;
    endcase
  end

  assign cpu.req_ready  = (state == IDLE);
  assign cpu.resp_valid = (state == RESP);
  assign cpu.resp_error = (state == RESP) && err_q;
  assign cpu.resp_rdata =
    (state == RESP && !err_q && !write_q) ? load_val : '0;

  assign ram_address   = addr_q;
  assign ram_isReading = (state != WR);
  assign ram_dataIn    = (state == WR) ? merged : '0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 11, RAM byte-address width.
REQ-002 SHALL have parameter MEM_DEPTH, default 2**ADDRESS_SIZE, RAM size in bytes.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-009 SHALL have port req_signed  input  1  sign-extend load result.
REQ-010 SHALL have port req_addr  input  ADDRESS_SIZE  byte address.
REQ-011 SHALL have port req_wdata  input  64  store data, right-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_error  output  1  request rejected; qualified by resp_valid.
REQ-014 SHALL have port resp_rdata  output  64  load result, right-aligned; qualified by resp_valid.
REQ-015 SHALL have port ram_address  output  ADDRESS_SIZE  drives RAM address.
REQ-016 SHALL have port ram_isReading  output  1  drives RAM isReading; 0 = RAM writes.
REQ-017 SHALL have port ram_dataIn  output  64  drives RAM dataIn.
REQ-018 SHALL have port ram_dataOut  input  64  RAM read data, combinational, big-endian (byte at address = bits 63:56).

Function
REQ-019 SHALL implement states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge with req_valid && req_ready, registering addr, size, write, signed and wdata.
REQ-021 SHALL reject when req_addr > MEM_DEPTH-8 (any size): IDLE -> RESP, no RAM write, resp_error = 1, resp_rdata = 0.
REQ-022 SHALL sequence a load as IDLE -> RD -> RESP; RD captures ram_dataOut at the end of the cycle.
REQ-023 SHALL sequence a dword store as IDLE -> WR -> RESP.
REQ-024 SHALL sequence a byte/half/word store (read-modify-write) as IDLE -> RD -> WR -> RESP.
REQ-025 SHALL hold ram_isReading = 1 in every state except WR, where it is 0 for exactly one cycle.
REQ-026 SHALL drive ram_address from the registered address, stable from the accept edge through the end of WR.
REQ-027 SHALL form the load result from the top N bytes of the captured word (N = 1, 2, 4, 8), right-aligned.
REQ-028 SHALL fill the upper bits of the load result with the sign bit of that field when req_signed = 1, else with zero; req_signed is ignored for dword loads.
REQ-029 SHALL drive ram_dataIn in WR as the captured word with its top N bytes replaced by the low N bytes of the registered wdata; for a dword store, ram_dataIn = wdata.
REQ-030 SHALL assert resp_valid for exactly one cycle, in RESP, then return to IDLE.
REQ-031 SHALL hold resp_rdata = 0 for stores.
REQ-032 SHALL produce latency from accept edge to resp_valid of: load 2 cycles, dword store 2, partial store 3, error 1.
REQ-033 SHALL ignore req_valid outside IDLE (no queuing).
REQ-034 SHALL sample new requests only on the edge leaving RESP -> IDLE or later, giving at most one request per 2 cycles.

Reset
REQ-035 SHALL on reset assertion, asynchronously, force state = IDLE, req_ready = 1, resp_valid = 0, resp_error = 0, resp_rdata = 0, ram_isReading = 1, ram_address = 0, ram_dataIn = 0.
REQ-036 SHALL abort any in-flight request when reset is asserted in any state, including WR, with no response issued.

Verification
REQ-037 SHALL verify: RAM[16..23] = 01..08, load dword addr 16 -> resp_valid 2 cycles after accept, resp_rdata = 0x0102030405060708.
REQ-038 SHALL verify: RAM[40] = 0x80, signed byte load addr 40 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
REQ-039 SHALL verify: RAM[0..7] = 11..88, half store addr 0, wdata 0xBEEF -> ram_isReading low once, 3 cycles to resp, RAM[0..7] = BE EF 33 44 55 66 77 88.
REQ-040 SHALL verify: load addr 2041 -> resp_error = 1 after 1 cycle; ram_isReading never 0.
REQ-041 SHALL verify: reset asserted during RD of a partial store -> no RAM write, no resp_valid, req_ready = 1 immediately.
REQ-042 SHALL verify: req_valid held high continuously -> back-to-back requests accepted only in IDLE, none lost or duplicated.
